// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters (port 0 execute, port 1 aux).
// Latency: accept at edge T, operands on alu_* during cycle T, result held on rsp_result from T+1 (>=3 cycles/op).
// Backpressure: req ready only in IDLE; the result is held until the owning port asserts its rsp ready.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   reqN_valid/ready/rs1/rs2/ctrl request handshake and operands for port N
//   rspN_valid/ready, rsp_result  held-response handshake, result shared by both ports
//   alu_rs1/rs2/control           registered ALU inputs; alu_result is the ALU's combinational output
//   busy                          high whenever an operation is in flight
// Configuration macro: ALU_ARB_RR_EN (defined: round-robin grant; undefined: port 0 fixed priority).

module alu_arbiter #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [XLEN-1:0]   req0_rs1,
  input  logic [XLEN-1:0]   req0_rs2,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [XLEN-1:0]   req1_rs1,
  input  logic [XLEN-1:0]   req1_rs2,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [XLEN-1:0]   rsp_result,
  output logic [XLEN-1:0]   alu_rs1,
  output logic [XLEN-1:0]   alu_rs2,
  output logic [CTRL_W-1:0] alu_control,
  input  logic [XLEN-1:0]   alu_result,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [XLEN-1:0]   alu_rs1_q, alu_rs1_d;
  logic [XLEN-1:0]   alu_rs2_q, alu_rs2_d;
  logic [CTRL_W-1:0] alu_control_q, alu_control_d;
  logic [XLEN-1:0]   rsp_result_q, rsp_result_d;
  logic              grant;
  logic              accept;

  // Grant is only meaningful when at least one valid is high; with a single
  // valid the requesting port always wins.
`ifdef ALU_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = ~req0_valid;
  end

  always_comb begin
    last_grant_d = accept ? grant : last_grant_q;
  end

  // Reset to 1 so port 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end
`else
  always_comb begin
    grant = ~req0_valid;
  end
`endif

  assign accept = (state_q == IDLE) && (req0_valid || req1_valid);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Next-state logic; only the owner's rsp ready can retire the response.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          owner_d = grant;
        end
      end
      EXEC:    state_d = RESP;
      RESP: begin
        if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: ready depends only on state, valids and grant state.
  always_comb begin
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    rsp0_valid = (state_q == RESP) && !owner_q;
    rsp1_valid = (state_q == RESP) && owner_q;
    busy       = (state_q != IDLE);
  end

  // Datapath: ALU inputs load only on accept and otherwise keep their value.
  always_comb begin
    alu_rs1_d     = alu_rs1_q;
    alu_rs2_d     = alu_rs2_q;
    alu_control_d = alu_control_q;
    rsp_result_d  = rsp_result_q;
    if (accept) begin
      alu_rs1_d     = grant ? req1_rs1  : req0_rs1;
      alu_rs2_d     = grant ? req1_rs2  : req0_rs2;
      alu_control_d = grant ? req1_ctrl : req0_ctrl;
    end
    if (state_q == EXEC) rsp_result_d = alu_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_rs1_q     <= '0;
      alu_rs2_q     <= '0;
      alu_control_q <= '0;
      rsp_result_q  <= '0;
    end else begin
      alu_rs1_q     <= alu_rs1_d;
      alu_rs2_q     <= alu_rs2_d;
      alu_control_q <= alu_control_d;
      rsp_result_q  <= rsp_result_d;
    end
  end

  assign alu_rs1     = alu_rs1_q;
  assign alu_rs2     = alu_rs2_q;
  assign alu_control = alu_control_q;
  assign rsp_result  = rsp_result_q;

endmodule
